// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin front end sharing one serial-operand ALU
// between NREQ requesters. Sequences opcode, operand A and operand B onto the
// ALU bus, captures a one- or two-word result and returns it with a one-cycle
// response pulse to the requester that owns the operation.
//
// Optional build macro ALU_RR_SCHED_TIMEOUT_EN: aborts a WAIT that lasts TMO
// cycles without alu_fin and answers with rsp_err=1 and a zero result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrate; grant pulses here, illegal opcodes skip the ALU
// S_ISSUE | opcode and operand A presented to the ALU
// S_OPA   | operand A held on ibus, opcode back to NOP
// S_OPB   | operand B on ibus
// S_WAIT  | wait for alu_fin, track previous obus word for two-word ops
// S_RESP  | one-cycle rsp_valid to the owner
module alu_rr_scheduler #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int TMO   = 64
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NREQ-1:0]         req,
  input  logic [4*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_lo,
  output logic [WIDTH-1:0]        rsp_hi,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [3:0]              alu_opcode,
  output logic [WIDTH-1:0]        alu_ibus,
  input  logic [WIDTH-1:0]        alu_obus,
  input  logic                    alu_fin
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_bad_param
    $error("alu_rr_scheduler: NREQ must be 2..8 and TMO at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_OPA, S_OPB, S_WAIT, S_RESP
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q, prev_q, lo_q, hi_q;
  logic              err_q;
  logic [PW-1:0]     owner_q, ptr_q;
  logic              win_found, win_legal, fin_cap, tmo_hit;
  logic [PW-1:0]     win_idx;
  logic [3:0]        win_op;

  // Round-robin search starting one past the last winner; held off in reset
  // so gnt stays low while rst_b is asserted.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (rst_b && !win_found && req[(int'(ptr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
    win_op    = req_op[win_idx*4 +: 4];
    win_legal = (win_op >= 4'd3) && (win_op <= 4'd11);
  end

`ifdef ALU_RR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] tmo_cnt;

  // WAIT-cycle counter, cleared on the way into WAIT.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                tmo_cnt <= '0;
    else if (state == S_OPB)   tmo_cnt <= '0;
    else if (state == S_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == CW'(TMO - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus ALU bus, grant and response strobes.
  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    rsp_valid  = '0;
    alu_opcode = OP_NOP;
    alu_ibus   = '0;
    fin_cap    = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          gnt[win_idx] = 1'b1;
          state_nxt    = win_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        alu_opcode = op_q;
        alu_ibus   = a_q;
        state_nxt  = S_OPA;
      end
      S_OPA: begin
        alu_ibus  = a_q;
        state_nxt = S_OPB;
      end
      S_OPB: begin
        alu_ibus  = b_q;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (alu_fin) begin
          fin_cap   = 1'b1;
          state_nxt = S_RESP;
        end else if (tmo_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_nxt          = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, pointer update and result registers; results only
  // change on the way into RESP so they hold between responses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      owner_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
      prev_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && win_found) begin
        op_q    <= win_op;
        a_q     <= req_a[win_idx*WIDTH +: WIDTH];
        b_q     <= req_b[win_idx*WIDTH +: WIDTH];
        owner_q <= win_idx;
        ptr_q   <= win_idx;
        if (!win_legal) begin
          lo_q  <= '0;
          hi_q  <= '0;
          err_q <= 1'b1;
        end
      end
      if (state == S_WAIT) prev_q <= alu_obus;
      if (fin_cap) begin
        lo_q  <= alu_obus;
        hi_q  <= (op_q == OP_MUL || op_q == OP_DIV) ? prev_q : '0;
        err_q <= 1'b0;
      end else if (tmo_hit) begin
        lo_q  <= '0;
        hi_q  <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_lo  = lo_q;
  assign rsp_hi  = hi_q;
  assign rsp_err = err_q;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: table of single-request vectors against a
// behavioural ALU, scoreboard of expected responses, and hand sequences for
// round-robin order, latency, early fin, illegal ops and reset mid-operation.
module tb_alu_rr_scheduler;
  localparam int W = 32;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_b;
  logic [N-1:0]     req;
  logic [4*N-1:0]   req_op;
  logic [W*N-1:0]   req_a, req_b;
  logic [N-1:0]     gnt, rsp_valid;
  logic [W-1:0]     rsp_lo, rsp_hi;
  logic             rsp_err, busy;
  logic [3:0]       alu_opcode;
  logic [W-1:0]     alu_ibus, alu_obus;
  logic             alu_fin;

  logic             m_fin, h_fin;
  logic [W-1:0]     m_obus, h_obus;
  bit               model_en;
  int               alu_lat;

  typedef struct {
    int         idx;
    logic [3:0] op;
    logic [W-1:0] a, b;
    int         lat;
    logic [W-1:0] lo, hi;
    logic       err;
  } vec_t;

  typedef struct {
    logic [N-1:0] owner;
    logic [W-1:0] lo, hi;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   tests = 0;
  int   fails = 0;

  assign alu_fin  = model_en ? m_fin  : h_fin;
  assign alu_obus = model_en ? m_obus : h_obus;

  alu_rr_scheduler #(.WIDTH(W), .NREQ(N), .TMO(64)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_lo(rsp_lo),
    .rsp_hi(rsp_hi), .rsp_err(rsp_err), .busy(busy), .alu_opcode(alu_opcode),
    .alu_ibus(alu_ibus), .alu_obus(alu_obus), .alu_fin(alu_fin)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(int i, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req[i]            = 1'b1;
    req_op[4*i +: 4]  = op;
    req_a[W*i +: W]   = a;
    req_b[W*i +: W]   = b;
  endtask

  task automatic push(logic [N-1:0] owner, logic [W-1:0] lo, logic [W-1:0] hi, logic err);
    exp_t e;
    e.owner = owner; e.lo = lo; e.hi = hi; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", busy, 0);
  endtask

  // Scoreboard: every response pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: rsp_valid=%b with nothing pending", rsp_valid);
      end else begin
        e_mon = sb.pop_front();
        if (rsp_valid !== e_mon.owner || rsp_lo !== e_mon.lo ||
            rsp_hi !== e_mon.hi || rsp_err !== e_mon.err) begin
          fails++;
          $display("FAIL rsp_data: got v=%b lo=%h hi=%h err=%b expected v=%b lo=%h hi=%h err=%b",
                   rsp_valid, rsp_lo, rsp_hi, rsp_err,
                   e_mon.owner, e_mon.lo, e_mon.hi, e_mon.err);
        end
      end
    end
  end

  // Behavioural serial ALU: opcode+A, A, B, then alu_lat cycles showing the
  // high word followed by the fin cycle carrying the low word.
  initial begin : alu_model
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b, m_lo, m_hi;
    logic [63:0]  prod;
    m_fin = 1'b0;
    m_obus = '0;
    forever begin
      @(negedge clk);
      if (model_en && rst_b && alu_opcode != 4'd0) begin
        m_op = alu_opcode;
        m_a  = alu_ibus;
        @(negedge clk);
        @(negedge clk);
        m_b  = alu_ibus;
        m_hi = 32'hDEAD_BEEF;
        case (m_op)
          4'd3:  m_lo = m_a + m_b;
          4'd4:  m_lo = m_a - m_b;
          4'd5:  m_lo = m_a >> m_b[4:0];
          4'd6:  m_lo = m_a << m_b[4:0];
          4'd7:  m_lo = m_a & m_b;
          4'd8:  m_lo = m_a | m_b;
          4'd9:  m_lo = -m_a;
          4'd10: begin prod = {32'd0, m_a} * {32'd0, m_b}; m_lo = prod[31:0]; m_hi = prod[63:32]; end
          4'd11: begin m_lo = (m_b != 0) ? m_a / m_b : '0; m_hi = (m_b != 0) ? m_a % m_b : '0; end
          default: m_lo = '0;
        endcase
        @(posedge clk); #1;
        for (int i = 0; i < alu_lat; i++) begin
          m_obus = m_hi;
          @(posedge clk); #1;
        end
        m_obus = m_lo;
        m_fin  = 1'b1;
        @(posedge clk); #1;
        m_fin  = 1'b0;
        m_obus = '0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[12];
    int   n;

    vecs[0]  = '{0, 4'd3,  32'd5,      32'd7,      0, 32'd12,         32'd0, 1'b0};
    vecs[1]  = '{1, 4'd4,  32'd10,     32'd3,      2, 32'd7,          32'd0, 1'b0};
    vecs[2]  = '{2, 4'd6,  32'd1,      32'd4,      0, 32'd16,         32'd0, 1'b0};
    vecs[3]  = '{3, 4'd5,  32'h80,     32'd3,      1, 32'h10,         32'd0, 1'b0};
    vecs[4]  = '{0, 4'd7,  32'hF0F0,   32'hFF00,   0, 32'hF000,       32'd0, 1'b0};
    vecs[5]  = '{1, 4'd8,  32'hF0,     32'h0F,     0, 32'hFF,         32'd0, 1'b0};
    vecs[6]  = '{2, 4'd9,  32'd1,      32'd0,      0, 32'hFFFF_FFFF,  32'd0, 1'b0};
    vecs[7]  = '{3, 4'd10, 32'h1_0000, 32'h1_0000, 1, 32'd0,          32'd1, 1'b0};
    vecs[8]  = '{0, 4'd11, 32'd100,    32'd7,      3, 32'd14,         32'd2, 1'b0};
    vecs[9]  = '{1, 4'd14, 32'd1,      32'd2,      0, 32'd0,          32'd0, 1'b1};
    vecs[10] = '{2, 4'd0,  32'd1,      32'd2,      0, 32'd0,          32'd0, 1'b1};
    vecs[11] = '{3, 4'd2,  32'd1,      32'd2,      0, 32'd0,          32'd0, 1'b1};

    rst_b = 1'b0;
    req = '0; req_op = '0; req_a = '0; req_b = '0;
    h_fin = 1'b0; h_obus = '0;
    model_en = 1'b1;
    alu_lat = 0;

    // Reset with every requester already asserting ADD 16*i+1.
    for (int i = 0; i < N; i++) set_req(i, 4'd3, 32'(16 * i), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_ibus", alu_ibus, 0);
    chk("rst_lo_hi_err", {rsp_lo, rsp_hi[30:0], rsp_err}, 0);

    // Round robin with all requests held.
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (gnt == '0 && n < 40);
      chk($sformatf("rr_gnt%0d", g), gnt, 4'b0001 << (g % 4));
      push(4'b0001 << (g % 4), 32'(16 * (g % 4) + 1), 32'd0, 1'b0);
    end
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    wait_idle();

    // Single ADD: bus sequencing and 5-cycle turnaround.
    @(posedge clk); #1;
    set_req(0, 4'd3, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_gnt", gnt, 4'b0001);
    push(4'b0001, 32'd12, 32'd0, 1'b0);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("issue_opcode", alu_opcode, 3);
    chk("issue_ibus", alu_ibus, 5);
    @(negedge clk);
    chk("opa_opcode", alu_opcode, 0);
    chk("opa_ibus", alu_ibus, 5);
    @(negedge clk);
    chk("opb_ibus", alu_ibus, 7);
    @(negedge clk);
    chk("wait_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("add_rsp_at_5", rsp_valid, 4'b0001);
    @(negedge clk);
    wait_idle();

    // Table of single requests.
    for (int k = 0; k < 12; k++) begin
      alu_lat = vecs[k].lat;
      @(posedge clk); #1;
      set_req(vecs[k].idx, vecs[k].op, vecs[k].a, vecs[k].b);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", k), gnt, 4'b0001 << vecs[k].idx);
      push(4'b0001 << vecs[k].idx, vecs[k].lo, vecs[k].hi, vecs[k].err);
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      wait_idle();
    end

    // Illegal opcode: immediate error response, ALU untouched.
    @(posedge clk); #1;
    set_req(1, 4'd14, 32'd1, 32'd2);
    @(negedge clk);
    chk("ill_gnt", gnt, 4'b0010);
    chk("ill_opcode0", alu_opcode, 0);
    push(4'b0010, 32'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("ill_rsp", rsp_valid, 4'b0010);
    chk("ill_err", rsp_err, 1);
    chk("ill_opcode1", alu_opcode, 0);
    @(negedge clk);
    chk("ill_idle", busy, 0);

    // MUL driven by hand, with fin asserted early in IDLE/ISSUE/OPA/OPB.
    model_en = 1'b0;
    @(posedge clk); #1;
    h_fin = 1'b1; h_obus = 32'h1234;
    @(negedge clk);
    chk("early_idle_rsp", rsp_valid, 0);
    chk("early_idle_busy", busy, 0);
    @(posedge clk); #1;
    set_req(2, 4'd10, 32'd3, 32'd4);
    @(negedge clk);
    chk("mul_gnt", gnt, 4'b0100);
    push(4'b0100, 32'h5555, 32'hAAAA, 1'b0);
    @(posedge clk); #1;
    req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("early_fin%0d", c), {busy, rsp_valid}, 5'b10000);
      @(posedge clk); #1;
    end
    h_fin = 1'b0; h_obus = 32'hAAAA;
    @(posedge clk); #1;
    h_fin = 1'b1; h_obus = 32'h5555;
    @(posedge clk); #1;
    h_fin = 1'b0; h_obus = '0;
    @(negedge clk);
    chk("mul_rsp", rsp_valid, 4'b0100);
    chk("mul_hi", rsp_hi, 32'hAAAA);
    chk("mul_lo", rsp_lo, 32'h5555);
    @(negedge clk);
    wait_idle();

    // Reset during WAIT of a DIV: everything clears, no response.
    @(posedge clk); #1;
    set_req(3, 4'd11, 32'd100, 32'd7);
    @(negedge clk);
    chk("div_gnt", gnt, 4'b1000);
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("div_wait_busy", busy, 1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lo", rsp_lo, 0);
    chk("mid_rst_hi", rsp_hi, 0);
    chk("mid_rst_misc", {rsp_err, rsp_valid, gnt, alu_opcode}, 0);
    chk("mid_rst_ibus", alu_ibus, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    h_fin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    h_fin = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);

    // WAIT without fin: timeout abort when enabled, otherwise it persists.
    @(posedge clk); #1;
    set_req(0, 4'd3, 32'd1, 32'd1);
    @(negedge clk);
    chk("tmo_gnt", gnt, 4'b0001);
`ifdef ALU_RR_SCHED_TIMEOUT_EN
    push(4'b0001, 32'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    req = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 200);
    chk("tmo_latency", n, 68);
    @(negedge clk);
    wait_idle();
`else
    @(posedge clk); #1;
    req = '0;
    repeat (100) @(negedge clk);
    chk("wait_persists", busy, 1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Round-robin scheduler that shares one serial-operand ALU (opcode + shared ibus, results on obus qualified by fin) between NREQ requesters.
- Accepts a complete request (opcode, operand A, operand B) from the winning requester.
- Sequences the opcode and both operands onto the ALU, captures the single- or two-word result, and returns it with a one-cycle response pulse.
- Sits between the ALU and the client blocks; it is the only driver of the ALU opcode and ibus.

Parameters:
- WIDTH, 32, ALU data width.
- NREQ, 4, number of requesters (2..8).
- TMO, 64, cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request, held high until granted
- req_op  in  4*NREQ  opcode of requester i at bits [4i+3:4i]
- req_a  in  WIDTH*NREQ  operand A of requester i
- req_b  in  WIDTH*NREQ  operand B of requester i
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the owner
- rsp_lo  out  WIDTH  result word 0
- rsp_hi  out  WIDTH  result word 1 (MUL/DIV only, else 0)
- rsp_err  out  1  error flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE
- alu_opcode  out  4  opcode to ALU
- alu_ibus  out  WIDTH  operand bus to ALU
- alu_obus  in  WIDTH  ALU result bus
- alu_fin  in  1  ALU completion

Behaviour:
- Reset values: state IDLE, all outputs 0, alu_opcode=NOP (0000), RR pointer=NREQ-1, internal op/A/B/owner registers cleared.
- Opcodes:
  - Legal: ADD=3, SUB=4, SHR=5, SHL=6, AND=7, OR=8, NEG=9, MUL=10, DIV=11.
  - Two-word: MUL and DIV.
  - Illegal: 0-2 and 12-15.
- Arbitration, IDLE only:
  - Search req from index ptr+1 upward, wrapping modulo NREQ; the first set bit wins.
  - gnt[w] pulses that same cycle; op/A/B/owner are registered; ptr<=w.
- FSM (one state per cycle unless noted):
  - IDLE: on grant, a legal op goes to ISSUE; an illegal op goes to RESP with err=1, and the ALU is untouched.
  - ISSUE: alu_opcode=op, alu_ibus=A. Go to OPA.
  - OPA: alu_opcode=NOP, alu_ibus=A. Go to OPB.
  - OPB: alu_opcode=NOP, alu_ibus=B. Go to WAIT.
  - WAIT: alu_opcode=NOP, alu_ibus=0.
    - prev<=alu_obus every cycle.
    - When alu_fin=1: lo<=alu_obus; hi<=prev for a two-word op, else hi<=0. Go to RESP.
  - RESP: rsp_valid[owner]=1; rsp_lo/rsp_hi/rsp_err driven. Go to IDLE.
- alu_opcode is non-NOP for exactly one cycle per operation, so a held opcode never relaunches the ALU.
- alu_fin is ignored outside WAIT. This covers the NOP-state fin the ALU asserts when idle.
- Worst-case turnaround for a combinational op: grant, ISSUE, OPA, OPB, WAIT (fin), RESP. That is rsp_valid 5 cycles after gnt when fin arrives in the first WAIT cycle.
- rsp_lo/rsp_hi/rsp_err hold their values after RESP until the next RESP. rsp_valid has no backpressure.
- Arbitration restarts only from IDLE. Back-to-back requests therefore cost one IDLE cycle between RESP and the next gnt.
- A req dropped before gnt is legal and is simply not served. A req that stays high after gnt is treated as a new request.
- Asserting rst_b low in any state returns immediately to the reset values. No response is issued for an in-flight operation.

Optional Feature:
- Macro: ALU_RR_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TMO without alu_fin, go to RESP with rsp_err=1, rsp_lo=0, rsp_hi=0.
  - The ALU is assumed idle afterwards.
- Undefined: no counter exists; WAIT persists until alu_fin.

Test Plan:
- req=0001, op=ADD, A=5, B=7, fin in first WAIT cycle with obus=12 -> gnt=0001; ISSUE shows opcode 3 with ibus=5; ibus=7 in OPB; rsp_valid=0001 with lo=12, hi=0, err=0, 5 cycles after gnt.
- req=1111 held continuously, all ADD, ALU returns instantly -> grants in order 0001, 0010, 0100, 1000, 0001, with no requester granted twice in a row.
- req[2], op=MUL, ALU drives obus=0xAAAA one cycle before fin and 0x5555 on the fin cycle -> rsp_valid=0100, hi=0xAAAA, lo=0x5555.
- req[1], op=14 -> gnt=0010, then rsp_valid=0010 with err=1 the next cycle; alu_opcode stays 0000 throughout.
- alu_fin pulsed during IDLE/ISSUE/OPA/OPB -> ignored; no early response.
- rst_b pulled low in WAIT of a DIV -> all outputs 0 and state IDLE immediately; no rsp_valid; with ALU_RR_SCHED_TIMEOUT_EN and TMO=64, no fin -> err=1 after 64 WAIT cycles.
